alu_phase_sequencer: RTL

Multi-cycle controller that sequences the ALU datapath through the six-phase cycle (fi0..fi5). It accepts one operation request at a time through a BGN/RDY handshake and decodes the opcode. Single-pass ops run through the phase sequence once. Iterative ops (MUL, DIV) loop the execute/shift phases WIDTH times. It drives the datapath load, enable, shift and write-back strobes, and signals completion with DONE.

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/alu_phase_sequencer_iter_counter.sv | 51 +++++
 rtl/alu_phase_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU phase sequencer:
//   - state_e    : controller states IDLE and F0..F5
//   - OP_*       : 3-bit opcode constants
//   - PH_FI0..5  : bit index of each phase inside the one-hot PH bus
//   - is_iterative(op) : true for MUL/DIV, which loop the F2/F3 pair
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_F2   = 3'd3,
    ST_F3   = 3'd4,
    ST_F4   = 3'd5,
    ST_F5   = 3'd6
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int PH_FI0 = 0;
  localparam int PH_FI1 = 1;
  localparam int PH_FI2 = 2;
  localparam int PH_FI3 = 3;
  localparam int PH_FI4 = 4;
  localparam int PH_FI5 = 5;

  // MUL and DIV run the execute/shift pair once per operand bit.
  function automatic logic is_iterative(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_phase_sequencer_iter_counter.sv
// ---------------------------------------------------------------------------
// iter_counter
// Iteration counter for the MUL/DIV execute/shift loop.
// Ports:
//   CLK   in  clock, rising edge
//   RST_N in  asynchronous active-low reset (clears the count)
//   clr   in  synchronous clear, wins over inc
//   inc   in  advance the count by one
//   count out current iteration index
//   tc    out terminal count, high when count == WIDTH-1
// ---------------------------------------------------------------------------
module iter_counter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  // Clear has priority so an abort on the last iteration still leaves zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// alu_phase_sequencer
// Multi-cycle controller walking the ALU datapath through phases fi0..fi5.
// One request at a time is taken through the BGN/RDY handshake; MUL/DIV loop
// the F2/F3 pair WIDTH times, illegal opcodes skip straight from F1 to F5.
// Ports:
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   BGN, OP         start request and opcode, sampled when RDY=1
//   ABORT           cancel the operation in progress
//   RDY, BUSY       idle / operation in progress (BUSY = ~RDY)
//   PH              one-hot phase, zero in IDLE
//   LD_AB, ALU_EN   operand load (F0), ALU result enable (F2)
//   SH_EN, WB       shift/accumulate enable (F3), write-back strobe (F4)
//   DONE, ERR       completion pulse (F5), illegal-opcode flag with DONE
//   ITER            iteration index, zero outside the iterative loop
// ---------------------------------------------------------------------------
module alu_phase_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          BGN,
  input  logic [2:0]    OP,
  input  logic          ABORT,
  output logic          RDY,
  output logic          BUSY,
  output logic [5:0]    PH,
  output logic          LD_AB,
  output logic          ALU_EN,
  output logic          SH_EN,
  output logic          WB,
  output logic          DONE,
  output logic          ERR,
  output logic [CW-1:0] ITER
);

  state_e     state_q;
  state_e     state_d;
  logic [2:0] op_q;
  logic [2:0] op_d;
  logic       iter_clr;
  logic       iter_inc;
  logic       iter_tc;

  iter_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (iter_clr),
    .inc   (iter_inc),
    .count (ITER),
    .tc    (iter_tc)
  );

  // State and latched opcode; reset drops straight back to IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state. ABORT only matters once busy; in IDLE a simultaneous BGN
  // is simply accepted. The opcode is captured only on acceptance, so OP
  // changes while busy are invisible.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    iter_clr = 1'b0;
    iter_inc = 1'b0;
    if ((state_q != ST_IDLE) && ABORT) begin
      state_d  = ST_IDLE;
      iter_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (BGN) begin
            state_d = ST_F0;
            op_d    = OP;
          end
        end
        ST_F0: state_d = ST_F1;
        ST_F1: state_d = (op_q == OP_ILL) ? ST_F5 : ST_F2;
        ST_F2: state_d = is_iterative(op_q) ? ST_F3 : ST_F4;
        ST_F3: begin
          if (iter_tc) begin
            state_d  = ST_F4;
            iter_clr = 1'b1;
          end else begin
            state_d  = ST_F2;
            iter_inc = 1'b1;
          end
        end
        ST_F4:   state_d = ST_F5;
        ST_F5:   state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    RDY    = 1'b0;
    PH     = '0;
    LD_AB  = 1'b0;
    ALU_EN = 1'b0;
    SH_EN  = 1'b0;
    WB     = 1'b0;
    DONE   = 1'b0;
    ERR    = 1'b0;
    unique case (state_q)
      ST_IDLE: RDY = 1'b1;
      ST_F0: begin
        PH[PH_FI0] = 1'b1;
        LD_AB      = 1'b1;
      end
      ST_F1: PH[PH_FI1] = 1'b1;
      ST_F2: begin
        PH[PH_FI2] = 1'b1;
        ALU_EN     = 1'b1;
      end
      ST_F3: begin
        PH[PH_FI3] = 1'b1;
        SH_EN      = 1'b1;
      end
      ST_F4: begin
        PH[PH_FI4] = 1'b1;
        WB         = 1'b1;
      end
      ST_F5: begin
        PH[PH_FI5] = 1'b1;
        DONE       = 1'b1;
        ERR        = (op_q == OP_ILL);
      end
      default: RDY = 1'b1;
    endcase
    BUSY = ~RDY;
  end

endmodule
